// File: rtl/time_chars_gen.sv
// Clock with BCD HH:MM:SS, adjust pulses and pause, rendered as a 2x16 ASCII display image.
// Define TIME_AMPM_EN to show 12-hour hours with an AM/PM marker; counting stays 24-hour.
module time_chars_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_hour,
  input  logic         inc_min,
  input  logic         pause,
  output logic [255:0] chars,
  output logic         upd
);

  localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PresLast = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hr1_q, hr0_q, mn1_q, mn0_q, sc1_q, sc0_q;
  logic [3:0]    hr1_d, hr0_d, mn1_d, mn0_d, sc1_d, sc0_d;
  logic          pend_q, pend_d;
  logic [255:0]  chars_q, img;
  logic          upd_q;
  logic          tick, due, adj;
  logic [8:0]    sec_inc, min_inc;
  logic [7:0]    hr_inc;

  // Returns {carry, tens, ones} for a 00-59 BCD counter.
  function automatic logic [8:0] bcd_inc60(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) begin
      if (tens == 4'd5) return 9'h100;
      return {1'b0, tens + 4'd1, 4'd0};
    end
    return {1'b0, tens, ones + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc24(input logic [3:0] tens, input logic [3:0] ones);
    if (tens == 4'd2 && ones == 4'd3) return 8'h00;
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

  function automatic logic [255:0] render(input logic [3:0] h1, input logic [3:0] h0,
                                          input logic [3:0] m1, input logic [3:0] m0,
                                          input logic [3:0] s1, input logic [3:0] s0,
                                          input logic       p);
    logic [255:0] r;
    logic [3:0]   d1, d0;
    r  = {32{8'h20}};
    d1 = h1;
    d0 = h0;
`ifdef TIME_AMPM_EN
    if (h1 == 4'd0 && h0 == 4'd0) begin
      d1 = 4'd1;
      d0 = 4'd2;
    end else if (h1 == 4'd1 && h0 >= 4'd3) begin
      d1 = 4'd0;
      d0 = h0 - 4'd2;
    end else if (h1 == 4'd2 && h0 <= 4'd1) begin
      d1 = 4'd0;
      d0 = h0 + 4'd8;
    end else if (h1 == 4'd2) begin
      d1 = 4'd1;
      d0 = h0 - 4'd2;
    end
    r[255-8*29 -: 16] = ((h1 == 4'd2) || (h1 == 4'd1 && h0 >= 4'd2)) ? "PM" : "AM";
`endif
    r[255-8*4  -: 8]  = {4'h3, d1};
    r[255-8*5  -: 8]  = {4'h3, d0};
    r[255-8*6  -: 8]  = 8'h3a;
    r[255-8*7  -: 8]  = {4'h3, m1};
    r[255-8*8  -: 8]  = {4'h3, m0};
    r[255-8*9  -: 8]  = 8'h3a;
    r[255-8*10 -: 8]  = {4'h3, s1};
    r[255-8*11 -: 8]  = {4'h3, s0};
    r[255-8*16 -: 40] = p ? "PAUSE" : "RUN  ";
    return r;
  endfunction

  assign sec_inc = bcd_inc60(sc1_q, sc0_q);
  assign min_inc = bcd_inc60(mn1_q, mn0_q);
  assign hr_inc  = bcd_inc24(hr1_q, hr0_q);

  always_comb begin
    tick    = !pause && (presc_q == PresLast);
    presc_d = presc_q;
    if (!pause) presc_d = tick ? '0 : presc_q + PW'(1);
    adj     = inc_hour || inc_min;
    due     = tick || pend_q;
    // A tick colliding with an adjust pulse is deferred rather than dropped.
    pend_d  = due && adj;
    {hr1_d, hr0_d} = {hr1_q, hr0_q};
    {mn1_d, mn0_d} = {mn1_q, mn0_q};
    {sc1_d, sc0_d} = {sc1_q, sc0_q};
    if (due && !adj) begin
      {sc1_d, sc0_d} = sec_inc[7:0];
      if (sec_inc[8]) begin
        {mn1_d, mn0_d} = min_inc[7:0];
        if (min_inc[8]) {hr1_d, hr0_d} = hr_inc;
      end
    end else begin
      if (inc_min)  {mn1_d, mn0_d} = min_inc[7:0];
      if (inc_hour) {hr1_d, hr0_d} = hr_inc;
    end
    img = render(hr1_q, hr0_q, mn1_q, mn0_q, sc1_q, sc0_q, pause);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pend_q  <= 1'b0;
      {hr1_q, hr0_q, mn1_q, mn0_q, sc1_q, sc0_q} <= '0;
      chars_q <= render(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
      upd_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pend_q  <= pend_d;
      {hr1_q, hr0_q, mn1_q, mn0_q, sc1_q, sc0_q} <=
          {hr1_d, hr0_d, mn1_d, mn0_d, sc1_d, sc0_d};
      chars_q <= img;
      upd_q   <= (img != chars_q);
    end
  end

  assign chars = chars_q;
  assign upd   = upd_q;

endmodule

// File: tb/tb_time_chars_gen.sv
// Directed self-checking bench for time_chars_gen at CLK_HZ=4; honours TIME_AMPM_EN.
module tb_time_chars_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inc_hour = 1'b0;
  logic         inc_min = 1'b0;
  logic         pause = 1'b0;
  logic [255:0] chars;
  logic         upd;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int upd_base = 0;

  time_chars_gen #(.CLK_HZ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .pause    (pause),
    .chars    (chars),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n falling edges, counting upd pulses seen there.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (upd === 1'b1) upd_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] asc(input int x);
    return 8'(48 + x);
  endfunction

  function automatic logic [127:0] l1(input int h, input int m, input int s);
    int dh;
    dh = h;
`ifdef TIME_AMPM_EN
    dh = (h % 12 == 0) ? 12 : h % 12;
`endif
    return {"    ", asc(dh / 10), asc(dh % 10), ":", asc(m / 10), asc(m % 10), ":",
            asc(s / 10), asc(s % 10), "    "};
  endfunction

  function automatic logic [127:0] l2(input bit p, input int h);
    logic [15:0] ap;
    ap = "  ";
`ifdef TIME_AMPM_EN
    ap = (h >= 12) ? "PM" : "AM";
`endif
    return {p ? "PAUSE" : "RUN  ", "        ", ap, " "};
  endfunction

  initial begin
    logic [255:0] rst_img;
`ifdef TIME_AMPM_EN
    rst_img = {"    12:00:00    ", "RUN          AM "};
`else
    rst_img = {"    00:00:00    ", "RUN             "};
`endif
    // Reset image, first second after release.
    step(2);
    check("rst_img", chars, rst_img);
    check("rst_upd", 256'(upd), 256'(0));
    rst = 1'b0;
    upd_base = upd_cnt;
    step(4);
    check("pre_tick", 256'(chars[255:128]), 256'(l1(0, 0, 0)));
    step(1);
    check("first_sec", 256'(chars[255:128]), 256'(l1(0, 0, 1)));
    check("first_upd", 256'(upd), 256'(1));
    step(1);
    check("upd_once", 256'(upd_cnt - upd_base), 256'(1));

    // Both adjusts in one cycle, then minute wrap without hour carry.
    pause = 1'b1;
    do_reset();
    inc_hour = 1'b1;
    inc_min  = 1'b1;
    step(1);
    inc_hour = 1'b0;
    inc_min  = 1'b0;
    step(2);
    check("both_inc", 256'(chars[255:128]), 256'(l1(1, 1, 0)));
    repeat (59) begin
      inc_min = 1'b1; step(1); inc_min = 1'b0; step(1);
    end
    step(1);
    check("min_wrap", 256'(chars[255:128]), 256'(l1(1, 0, 0)));

    // 23:59:59 rolls to 00:00:00 on one tick.
    do_reset();
    repeat (23) begin
      inc_hour = 1'b1; step(1); inc_hour = 1'b0; step(1);
    end
    repeat (59) begin
      inc_min = 1'b1; step(1); inc_min = 1'b0; step(1);
    end
    step(2);
    check("set_2359", chars, {l1(23, 59, 0), l2(1, 23)});
    pause = 1'b0;
    step(237);
    check("at_235959", 256'(chars[255:128]), 256'(l1(23, 59, 59)));
    step(4);
    check("day_wrap", chars, {l1(0, 0, 0), l2(0, 0)});

    // Minute adjust on the tick cycle defers the tick by one cycle.
    do_reset();
    step(239);
    check("at_0059", 256'(chars[255:128]), 256'(l1(0, 0, 59)));
    inc_min = 1'b1;
    step(1);
    inc_min = 1'b0;
    step(1);
    check("defer_a", 256'(chars[255:128]), 256'(l1(0, 1, 59)));
    step(1);
    check("defer_b", 256'(chars[255:128]), 256'(l1(0, 2, 0)));
    step(3);
    check("after_defer", 256'(chars[255:128]), 256'(l1(0, 2, 1)));

    // Pause for 20 cycles; prescaler must resume from its held value.
    upd_base = upd_cnt;
    pause = 1'b1;
    step(20);
    check("pause_time", chars, {l1(0, 2, 1), l2(1, 0)});
    check("pause_upd", 256'(upd_cnt - upd_base), 256'(1));
    pause = 1'b0;
    step(1);
    check("run_again", 256'(chars[127:0]), 256'(l2(0, 0)));
    step(2);
    check("held_presc", 256'(chars[255:128]), 256'(l1(0, 2, 1)));
    step(1);
    check("resume", 256'(chars[255:128]), 256'(l1(0, 2, 2)));

    // Reset while a deferred tick is pending.
    do_reset();
    step(15);
    check("at_0003", 256'(chars[255:128]), 256'(l1(0, 0, 3)));
    inc_min = 1'b1;
    step(1);
    inc_min = 1'b0;
    rst = 1'b1;
    step(1);
    check("pend_rst", chars, rst_img);
    check("pend_rst_upd", 256'(upd), 256'(0));
    rst = 1'b0;
    step(3);
    check("no_pend", chars, rst_img);
    step(1);
    check("no_pend2", 256'(chars[255:128]), 256'(l1(0, 0, 0)));
    step(1);
    check("restart", 256'(chars[255:128]), 256'(l1(0, 0, 1)));

`ifdef TIME_AMPM_EN
    pause = 1'b1;
    do_reset();
    repeat (13) begin
      inc_hour = 1'b1; step(1); inc_hour = 1'b0; step(1);
    end
    step(1);
    check("ampm_13", chars, {"    01:00:00    ", "PAUSE        PM "});
    repeat (11) begin
      inc_hour = 1'b1; step(1); inc_hour = 1'b0; step(1);
    end
    step(1);
    check("ampm_00", chars, {"    12:00:00    ", "PAUSE        AM "});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_chars_gen.md
TIME_CHARS_GEN -- requirements
Module: time_chars_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inc_hour  input  1  one-cycle pulse, already synchronised and debounced; advance hours.
REQ-005 SHALL have port inc_min  input  1  one-cycle pulse, already synchronised and debounced; advance minutes.
REQ-006 SHALL have port pause  input  1  level; high freezes timekeeping.
REQ-007 SHALL have port chars  output  256  ASCII display image, 32 bytes, byte k at [255-8k:248-8k]; bytes 0-15 line 1, bytes 16-31 line 2; registered.
REQ-008 SHALL have port upd  output  1  one-cycle pulse in the cycle chars takes a new value.

Function
REQ-009 SHALL hold time as BCD hour tens/ones (00-23), minute tens/ones (00-59), second tens/ones (00-59); no binary-to-BCD conversion.
REQ-010 SHALL run prescaler 0..CLK_HZ-1 while pause low; tick asserted in the cycle prescaler = CLK_HZ-1, which wraps to 0.
REQ-011 SHALL hold prescaler and ignore ticks while pause high; inc_hour/inc_min remain effective.
REQ-012 SHALL advance seconds on tick, carry 59->00 into minutes, 59->00 into hours, 23->00; 23:59:59 -> 00:00:00 on one tick.
REQ-013 SHALL on inc_min set minutes (m+1) mod 60, no carry into hours, seconds and prescaler unchanged.
REQ-014 SHALL on inc_hour set hours (h+1) mod 24, minutes and seconds unchanged.
REQ-015 SHALL on inc_hour and inc_min in same cycle apply both.
REQ-016 SHALL, when tick coincides with inc_hour or inc_min, apply the increment this cycle, set pending flag, and apply the deferred tick next cycle; no tick ever lost.
REQ-017 SHALL apply pending tick even if pause rises in the following cycle.
REQ-018 SHALL render chars one cycle after any time or pause change (latency 1); upd high in exactly that cycle, low otherwise.
REQ-019 SHALL render line 1 as four spaces, HH, ':', MM, ':', SS, four spaces (bytes 4-11 hold digits and colons).
REQ-020 SHALL render line 2 bytes 16-20 as "RUN  " when pause low, "PAUSE" when high; bytes 21-31 spaces unless REQ-025 applies.
REQ-021 SHALL output digits as ASCII 0x30+BCD.

Reset
REQ-022 SHALL on rst high at a clock edge clear time to 00:00:00, prescaler 0, pending 0, upd 0, overriding all inputs, including mid-second and with a tick pending.
REQ-023 SHALL load chars at reset with "    00:00:00    " + "RUN" + 13 spaces (12 h variant per REQ-025).
REQ-024 SHALL resume counting the cycle after rst falls; first tick CLK_HZ cycles later.

Configuration
REQ-025 SHALL, with macro TIME_AMPM_EN defined, display hours 12-hour (00->12, 13->01, 12->12) and bytes 29-30 "AM" for internal 00-11, "PM" for 12-23; internal counting stays 24-hour; reset image "    12:00:00    " line 2 ending "AM ".
REQ-026 SHALL, without TIME_AMPM_EN, display 24-hour and bytes 29-30 spaces; no 12-hour logic synthesised.

Verification (CLK_HZ=4)
REQ-027 SHALL cover: rst then 4 cycles -> upd one pulse, chars line 1 "    00:00:01    ".
REQ-028 SHALL cover: 23 inc_hour, 59 inc_min, then 59 ticks -> one further tick gives "    00:00:00    ", no hour carry leak.
REQ-029 SHALL cover: inc_min on tick cycle at 00:00:59 -> next cycle 00:01:59, following cycle 00:02:00.
REQ-030 SHALL cover: pause high 20 cycles -> seconds unchanged, line 2 "PAUSE", upd once on pause rise; pause low -> "RUN  ", counting resumes from held prescaler.
REQ-031 SHALL cover: rst asserted with pending tick at 00:00:03 -> chars reset image next cycle, no deferred tick applied.
REQ-032 SHALL cover with TIME_AMPM_EN: 13 inc_hour -> "    01:00:00    ", bytes 29-30 "PM"; 11 more -> "12", "AM".
